// File: rtl/cdb_arbiter.sv
// cdb_arbiter
// Common-data-bus arbiter. Each producer channel owns a small circular FIFO of
// {data, label} results. One FIFO head is granted per cycle and driven onto a
// registered broadcast bus. The grant is round-robin or fixed-priority (lowest
// index wins), depending on RR_MODE.
//
// Ports
//   clk      : clock, all state changes on the rising edge
//   nRST     : synchronous reset, active high (despite the legacy name)
//   flush    : synchronous clear of all FIFOs and the round-robin pointer
//   req      : per-channel result-valid strobe
//   data     : packed results, channel i at [i*DATA_W +: DATA_W]
//   label    : packed tags, channel i at [i*LABEL_W +: LABEL_W]; 0 = no producer
//   ack      : combinational accept per channel
//   full     : per-channel FIFO full, derived from registered occupancy
//   BCEN     : broadcast valid (registered, one pulse per entry)
//   BCdata   : broadcast data (registered, holds when BCEN = 0)
//   BClabel  : broadcast tag (registered, holds when BCEN = 0)
module cdb_arbiter #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned LABEL_W  = 4,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned RR_MODE  = 1
) (
    input  logic                        clk,
    input  logic                        nRST,
    input  logic                        flush,
    input  logic [CHANNELS-1:0]         req,
    input  logic [CHANNELS*DATA_W-1:0]  data,
    input  logic [CHANNELS*LABEL_W-1:0] label,
    output logic [CHANNELS-1:0]         ack,
    output logic [CHANNELS-1:0]         full,
    output logic                        BCEN,
    output logic [DATA_W-1:0]           BCdata,
    output logic [LABEL_W-1:0]          BClabel
);

    localparam int unsigned IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0]   count_q     [CHANNELS];
    logic [CNT_W-1:0]   count_d     [CHANNELS];
    logic [PTR_W-1:0]   wr_ptr_q    [CHANNELS];
    logic [PTR_W-1:0]   wr_ptr_d    [CHANNELS];
    logic [PTR_W-1:0]   rd_ptr_q    [CHANNELS];
    logic [PTR_W-1:0]   rd_ptr_d    [CHANNELS];
    logic [DATA_W-1:0]  mem_data_q  [CHANNELS][DEPTH];
    logic [DATA_W-1:0]  mem_data_d  [CHANNELS][DEPTH];
    logic [LABEL_W-1:0] mem_label_q [CHANNELS][DEPTH];
    logic [LABEL_W-1:0] mem_label_d [CHANNELS][DEPTH];

    logic [IDX_W-1:0]   rr_q, rr_d;
    logic               bcen_q, bcen_d;
    logic [DATA_W-1:0]  bcdata_q, bcdata_d;
    logic [LABEL_W-1:0] bclabel_q, bclabel_d;

    logic [CHANNELS-1:0] nonempty;
    logic [CHANNELS-1:0] pop;
    logic                grant_valid;
    logic [IDX_W-1:0]    grant_idx;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Status uses the registered count only, so a full FIFO refuses a push
    // even in a cycle where it is also being popped.
    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            full[i]     = (count_q[i] == CNT_W'(DEPTH));
            nonempty[i] = (count_q[i] != '0);
            ack[i]      = req[i]
                        && (count_q[i] != CNT_W'(DEPTH))
                        && (label[i*LABEL_W +: LABEL_W] != '0)
                        && !flush
                        && !nRST;
        end
    end

    // Walk the channels starting at rr_q (round-robin) or at 0 (fixed
    // priority); the first non-empty one wins.
    always_comb begin : arbitrate
        int unsigned cand;
        cand        = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        pop         = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (RR_MODE != 0) begin
                cand = (32'(rr_q) + k) % CHANNELS;
            end else begin
                cand = k;
            end
            if (!grant_valid && nonempty[IDX_W'(cand)]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
        if (grant_valid && !flush) begin
            pop[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mem_data_d  = mem_data_q;
        mem_label_d = mem_label_q;
        rr_d        = rr_q;
        bcen_d      = 1'b0;
        bcdata_d    = bcdata_q;
        bclabel_d   = bclabel_q;

        if (flush) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                count_d[i]  = '0;
                wr_ptr_d[i] = '0;
                rd_ptr_d[i] = '0;
            end
            rr_d = '0;
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (ack[i]) begin
                    mem_data_d[i][wr_ptr_q[i]]  = data[i*DATA_W +: DATA_W];
                    mem_label_d[i][wr_ptr_q[i]] = label[i*LABEL_W +: LABEL_W];
                    wr_ptr_d[i]                 = ptr_inc(wr_ptr_q[i]);
                end
                if (pop[i]) begin
                    rd_ptr_d[i] = ptr_inc(rd_ptr_q[i]);
                end
                case ({ack[i], pop[i]})
                    2'b10:   count_d[i] = count_q[i] + 1'b1;
                    2'b01:   count_d[i] = count_q[i] - 1'b1;
                    default: count_d[i] = count_q[i];
                endcase
            end

            if (grant_valid) begin
                bcen_d    = 1'b1;
                bcdata_d  = mem_data_q[grant_idx][rd_ptr_q[grant_idx]];
                bclabel_d = mem_label_q[grant_idx][rd_ptr_q[grant_idx]];
                if (RR_MODE != 0) begin
                    rr_d = (grant_idx == IDX_W'(CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (nRST) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                count_q[i]  <= '0;
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                for (int unsigned j = 0; j < DEPTH; j++) begin
                    mem_data_q[i][j]  <= '0;
                    mem_label_q[i][j] <= '0;
                end
            end
            rr_q      <= '0;
            bcen_q    <= 1'b0;
            bcdata_q  <= '0;
            bclabel_q <= '0;
        end else begin
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_data_q  <= mem_data_d;
            mem_label_q <= mem_label_d;
            rr_q        <= rr_d;
            bcen_q      <= bcen_d;
            bcdata_q    <= bcdata_d;
            bclabel_q   <= bclabel_d;
        end
    end

    assign BCEN    = bcen_q;
    assign BCdata  = bcdata_q;
    assign BClabel = bclabel_q;

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Parametrised common-data-bus arbiter sitting between the functional-unit result ports (ALU, MUL, DIV, load/store) and the broadcast bus that feeds the register file and every reservation station. Each producer channel gets its own small result FIFO, so a unit whose result is not granted does not stall. A round-robin (or optional fixed-priority) arbiter picks one FIFO head per cycle and drives a registered broadcast of {BCEN, BCdata, BClabel}.

## Interface
- CHANNELS, 4, number of producer channels (2..8); channel 0 = ALU, 1 = MUL, 2 = DIV, 3 = LS in the current core
- DATA_W, 32, result data width
- LABEL_W, 4, reservation-station tag width; label 0 means "no producer"
- DEPTH, 2, entries per channel FIFO (1..4)
- RR_MODE, 1, 1 = round-robin, 0 = fixed priority (lowest index wins)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- nRST  in  1  reset, synchronous and active-high (asserted = 1); one clock, reset is synchronous and active-high
- flush  in  1  synchronous clear of all FIFOs and the round-robin pointer
- req  in  CHANNELS  per-channel result-valid strobe
- data  in  CHANNELS*DATA_W  packed results, channel i at [i*DATA_W +: DATA_W]
- label  in  CHANNELS*LABEL_W  packed tags, channel i at [i*LABEL_W +: LABEL_W]
- ack  out  CHANNELS  combinational: req[i] & ~full[i] & (label_i != 0) & ~flush
- full  out  CHANNELS  registered: channel FIFO holds DEPTH entries
- BCEN  out  1  broadcast valid, registered
- BCdata  out  DATA_W  broadcast data, registered
- BClabel  out  LABEL_W  broadcast tag, registered

## Operation
- Per channel: circular FIFO of DEPTH {data,label} entries, read/write pointers wrap at DEPTH, count 0..DEPTH.
- Enqueue when ack[i] = 1. full[i] is sampled from the registered count, so a full FIFO refuses an enqueue even when it pops in the same cycle.
- Requests with label 0 are dropped: no enqueue, ack stays 0.
- Arbitration runs every cycle over non-empty FIFOs (count != 0, before that cycle's enqueue):
  - RR_MODE=1: search starts at pointer rr and wraps modulo CHANNELS; the first non-empty channel g wins; rr <= (g+1) mod CHANNELS. rr is unchanged when no channel is granted.
  - RR_MODE=0: lowest non-empty index wins; rr is unused.
- Winner's head is popped and loaded into the broadcast registers with BCEN <= 1. With no winner, BCEN <= 0, while BCdata and BClabel hold their previous value.
- At most one pop per cycle in total; enqueue and pop on the same channel in the same cycle are both allowed when not full, and count is unchanged.
- flush = 1:
  - all counts and pointers reset and rr <= 0
  - no grant is made and BCEN <= 0
  - ack is forced to 0
  - a broadcast already registered from the previous cycle still appears
- nRST = 1 (any time, including mid-burst):
  - all FIFO contents are discarded and rr = 0
  - BCEN = 0, BCdata = 0, BClabel = 0
  - full = 0, ack = 0
- Reset has priority over flush.

## Timing
- Reset values: BCEN 0, BCdata 0, BClabel 0, full all 0, rr 0.
- Latency: with req/ack at cycle t (captured at edge t), the entry is eligible in cycle t+1. If it is granted in t+1, BCEN = 1 during cycle t+2. Minimum latency is 2 cycles and there is no bypass path.
- Throughput: one broadcast per cycle sustained while any FIFO is non-empty.
- full[i] rises the cycle after the DEPTH-th entry is captured. It falls the cycle after a pop that leaves count < DEPTH.
- BCEN is a single-cycle pulse per entry. Back-to-back grants give consecutive BCEN = 1 cycles.
- Round-robin fairness: with all CHANNELS FIFOs continuously non-empty, each channel is granted exactly once per CHANNELS consecutive cycles.

## Test plan
- Reset then idle: nRST high 2 cycles, then low 5 cycles, no req -> BCEN stays 0, BCdata = 0, BClabel = 0, full = 0000.
- Single result: req[1] with data 0x0000_00A5, label 6 at cycle 3 -> ack[1] = 1 in cycle 3; BCEN = 1, BCdata = 0xA5, BClabel = 6 in cycle 5 only.
- Simultaneous requests, RR_MODE=1: at cycle 3, channels 0..3 req with labels 1, 2, 3, 4 (data = 0x10·label) -> broadcasts in cycles 5, 6, 7, 8 with labels 1, 2, 3, 4; a second identical burst broadcasts labels 1, 2, 3, 4 again in order.
- Fixed priority, RR_MODE=0: channel 0 holds 2 entries (labels 1, 5) and channel 2 holds 1 entry (label 3) -> broadcast order is 1, 5, 3.
- Backpressure and drop, DEPTH=2: channel 2 requests on 4 consecutive cycles while channel 0 is saturated (RR_MODE=0) -> ack[2] = 1, 1, 0, 0 and full[2] = 1 from the third cycle. A req with label 0 gives ack = 0 and no broadcast.
- Flush and reset mid-operation: 3 entries pending, flush high 1 cycle -> at most the already-registered broadcast appears, then BCEN = 0 and all counts are 0. Repeat with nRST instead -> BCEN = 0 in the cycle after reset is sampled.
